// File: rtl/axi_cmd_router.sv
// Command-frame decoder/router: matches a header code against a table, tags the
// frame with tdest/tuser and forwards it through one registered AXI4-Stream stage.
module axi_cmd_router #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_CMD     = 4,
  parameter logic [32*NUM_CMD-1:0] CMD_TABLE   = {32'h52524646, 32'h52524343,
                                                  32'h57574646, 32'h57574343},
  parameter int unsigned           TDEST_WIDTH = 4,
  parameter bit                    DEDUP_EN    = 1'b1
) (
  input  logic                      axi_tclk,
  input  logic                      axi_treset,
  input  logic                      enable_rx_decode,
  input  logic [DATA_WIDTH-1:0]     cmd_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_axis_tkeep,
  input  logic                      cmd_axis_tvalid,
  input  logic                      cmd_axis_tlast,
  output logic                      cmd_axis_tready,
  output logic [DATA_WIDTH-1:0]     tdata,
  output logic [DATA_WIDTH/8-1:0]   tkeep,
  output logic                      tvalid,
  output logic                      tlast,
  output logic [TDEST_WIDTH-1:0]    tdest,
  output logic [3:0]                tid,
  output logic [31:0]               tuser,
  input  logic                      tready,
  output logic                      err_unknown,
  output logic                      err_short,
  output logic                      dup_drop
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, GET_ID, EMIT_HDR, FWD, DROP} state_t;

  state_t                 state;
  logic [31:0]            cmd;
  logic [31:0]            id;
  logic [31:0]            last_id;
  logic [TDEST_WIDTH-1:0] dest;
  logic                   hdr_last;
  logic                   match;
  logic [TDEST_WIDTH-1:0] match_idx;
  logic                   load_ok;
  logic                   ready_state;
  logic                   in_acc;

  assign tid     = 4'd0;
  assign load_ok = !tvalid || tready;
  assign in_acc  = cmd_axis_tvalid && cmd_axis_tready;

  // Table lookup; scanning downwards lets the lowest matching index win.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = int'(NUM_CMD) - 1; i >= 0; i--) begin
      if (cmd_axis_tdata[31:0] == CMD_TABLE[32*i +: 32]) begin
        match     = 1'b1;
        match_idx = TDEST_WIDTH'(i);
      end
    end
  end

  always_comb begin
    ready_state = 1'b0;
    case (state)
      IDLE:        ready_state = enable_rx_decode;
      GET_ID,
      DROP:        ready_state = 1'b1;
      EMIT_HDR:    ready_state = 1'b0;
      FWD:         ready_state = load_ok;
      default:     ready_state = 1'b0;
    endcase
  end

  // Held low while reset is asserted so nothing is accepted during reset.
  assign cmd_axis_tready = ready_state && !axi_treset;

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      state       <= IDLE;
      cmd         <= '0;
      id          <= '0;
      last_id     <= '0;
      dest        <= '0;
      hdr_last    <= 1'b0;
      tdata       <= '0;
      tkeep       <= '0;
      tvalid      <= 1'b0;
      tlast       <= 1'b0;
      tdest       <= '0;
      tuser       <= '0;
      err_unknown <= 1'b0;
      err_short   <= 1'b0;
      dup_drop    <= 1'b0;
    end else begin
      err_unknown <= 1'b0;
      err_short   <= 1'b0;
      dup_drop    <= 1'b0;
      if (tvalid && tready) tvalid <= 1'b0;

      case (state)
        IDLE: if (in_acc) begin
          if (cmd_axis_tlast) begin
            err_short <= 1'b1;
          end else if (match) begin
            cmd   <= cmd_axis_tdata[31:0];
            dest  <= match_idx;
            state <= GET_ID;
          end else begin
            err_unknown <= 1'b1;
            state       <= DROP;
          end
        end
        GET_ID: if (in_acc) begin
          if (DEDUP_EN && (cmd_axis_tdata[31:0] == last_id)) begin
            dup_drop <= 1'b1;
            state    <= cmd_axis_tlast ? IDLE : DROP;
          end else begin
            id       <= cmd_axis_tdata[31:0];
            last_id  <= cmd_axis_tdata[31:0];
            hdr_last <= cmd_axis_tlast;
            state    <= EMIT_HDR;
          end
        end
        EMIT_HDR: if (load_ok) begin
          tvalid <= 1'b1;
          tdata  <= DATA_WIDTH'(cmd);
          tkeep  <= {KEEP_WIDTH{1'b1}};
          tlast  <= hdr_last;
          tdest  <= dest;
          tuser  <= id;
          state  <= hdr_last ? IDLE : FWD;
        end
        // Input ready already implies the output register is free.
        FWD: if (in_acc) begin
          tvalid <= 1'b1;
          tdata  <= cmd_axis_tdata;
          tkeep  <= cmd_axis_tkeep;
          tlast  <= cmd_axis_tlast;
          if (cmd_axis_tlast) state <= IDLE;
        end
        DROP: if (in_acc && cmd_axis_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cmd_router.sv
// Scoreboard bench for axi_cmd_router: one instance with ID de-duplication and one
// without, driven with the same frames through per-instance valid handshakes.
module tb_axi_cmd_router;

  localparam int unsigned DW = 32;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned TW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [TW-1:0] dest;
    logic [31:0]   user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] in_data;
  logic [KW-1:0] in_keep;
  logic [1:0]    in_valid;
  logic          in_last;
  logic [1:0]    in_ready;
  logic          tready;
  int            tready_mode;

  logic [DW-1:0] o_data  [2];
  logic [KW-1:0] o_keep  [2];
  logic          o_valid [2];
  logic          o_last  [2];
  logic [TW-1:0] o_dest  [2];
  logic [3:0]    o_tid   [2];
  logic [31:0]   o_user  [2];
  logic          p_unk   [2];
  logic          p_short [2];
  logic          p_dup   [2];

  beat_t exp_q [2][$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cnt_unk   [2];
  int    cnt_short [2];
  int    cnt_dup   [2];

  always #5 clk = ~clk;

  axi_cmd_router #(.DEDUP_EN(1'b1)) dut (
    .axi_tclk(clk), .axi_treset(rst), .enable_rx_decode(en),
    .cmd_axis_tdata(in_data), .cmd_axis_tkeep(in_keep), .cmd_axis_tvalid(in_valid[0]),
    .cmd_axis_tlast(in_last), .cmd_axis_tready(in_ready[0]),
    .tdata(o_data[0]), .tkeep(o_keep[0]), .tvalid(o_valid[0]), .tlast(o_last[0]),
    .tdest(o_dest[0]), .tid(o_tid[0]), .tuser(o_user[0]), .tready(tready),
    .err_unknown(p_unk[0]), .err_short(p_short[0]), .dup_drop(p_dup[0])
  );

  axi_cmd_router #(.DEDUP_EN(1'b0)) dut_nodedup (
    .axi_tclk(clk), .axi_treset(rst), .enable_rx_decode(en),
    .cmd_axis_tdata(in_data), .cmd_axis_tkeep(in_keep), .cmd_axis_tvalid(in_valid[1]),
    .cmd_axis_tlast(in_last), .cmd_axis_tready(in_ready[1]),
    .tdata(o_data[1]), .tkeep(o_keep[1]), .tvalid(o_valid[1]), .tlast(o_last[1]),
    .tdest(o_dest[1]), .tid(o_tid[1]), .tuser(o_user[1]), .tready(tready),
    .err_unknown(p_unk[1]), .err_short(p_short[1]), .dup_drop(p_dup[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output sink: 0 = stall, 1 = always ready, 2 = toggle every cycle.
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (tready_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = ~tready;
      endcase
    end
  end

  // Monitor: pop the scoreboard on every completed output beat and count pulses.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (p_unk[k])   cnt_unk[k]++;
        if (p_short[k]) cnt_short[k]++;
        if (p_dup[k])   cnt_dup[k]++;
        if (o_valid[k] && tready) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_beat[%0d]", k), 64'(o_data[k]), 64'hDEAD);
          end else begin
            beat_t e;
            e = exp_q[k].pop_front();
            chk($sformatf("tdata[%0d]", k), 64'(o_data[k]), 64'(e.data));
            chk($sformatf("tkeep[%0d]", k), 64'(o_keep[k]), 64'(e.keep));
            chk($sformatf("tlast[%0d]", k), 64'(o_last[k]), 64'(e.last));
            chk($sformatf("tdest[%0d]", k), 64'(o_dest[k]), 64'(e.dest));
            chk($sformatf("tuser[%0d]", k), 64'(o_user[k]), 64'(e.user));
          end
        end
      end
    end
  end

  task automatic push(input logic [1:0] mask, input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic [TW-1:0] dst, input logic [31:0] usr);
    beat_t b;
    b = '{data: d, keep: k, last: l, dest: dst, user: usr};
    if (mask[0]) exp_q[0].push_back(b);
    if (mask[1]) exp_q[1].push_back(b);
  endtask

  // Present one beat to both instances; each drops its valid once it has taken the beat.
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    logic [1:0] acc;
    int n;
    n        = 0;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 2'b11;
    while (in_valid != 2'b00 && n < 200) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      in_valid = in_valid & ~acc;
      n++;
    end
    if (in_valid != 2'b00) chk("send_timeout", 64'(in_valid), 64'd0);
    in_valid = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; in_data = '0; in_keep = '0; in_valid = 2'b00; in_last = 1'b0;
    tready_mode = 1;
    for (int k = 0; k < 2; k++) begin cnt_unk[k] = 0; cnt_short[k] = 0; cnt_dup[k] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(o_valid[0]), 64'd0);
    chk("rst_in_ready", 64'(in_ready[0]), 64'd0);
    chk("rst_tdata", 64'(o_data[0]), 64'd0);
    chk("rst_tuser", 64'(o_user[0]), 64'd0);
    chk("rst_pulses", 64'({p_unk[0], p_short[0], p_dup[0]}), 64'd0);
    chk("tid_zero", 64'(o_tid[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame, header latency two cycles after the ID beat.
    push(2'b11, 32'h57574343, 4'hF, 1'b0, 4'd0, 32'd7);
    push(2'b11, 32'hA0A00001, 4'hF, 1'b0, 4'd0, 32'd7);
    push(2'b11, 32'hB0B00002, 4'h3, 1'b1, 4'd0, 32'd7);
    send(32'h57574343, 4'hF, 1'b0);
    send(32'h00000007, 4'hF, 1'b0);
    chk("hdr_not_early", 64'(o_valid[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("hdr_latency", 64'(o_valid[0]), 64'd1);
    send(32'hA0A00001, 4'hF, 1'b0);
    send(32'hB0B00002, 4'h3, 1'b1);
    drain();

    // Toggling backpressure, then a header-only frame.
    tready_mode = 2;
    push(2'b11, 32'h57574343, 4'hF, 1'b0, 4'd0, 32'd9);
    push(2'b11, 32'hA0A00011, 4'hF, 1'b0, 4'd0, 32'd9);
    push(2'b11, 32'hB0B00012, 4'hF, 1'b1, 4'd0, 32'd9);
    push(2'b11, 32'h52524646, 4'hF, 1'b1, 4'd3, 32'd8);
    send(32'h57574343, 4'hF, 1'b0);
    send(32'h00000009, 4'hF, 1'b0);
    send(32'hA0A00011, 4'hF, 1'b0);
    send(32'hB0B00012, 4'hF, 1'b1);
    send(32'h52524646, 4'hF, 1'b0);
    send(32'h00000008, 4'hF, 1'b1);
    drain();
    tready_mode = 1;

    // Unknown code is dropped, next frame routes normally.
    send(32'h12345678, 4'hF, 1'b0);
    chk("err_unknown_pulse", 64'(p_unk[0]), 64'd1);
    send(32'h00000055, 4'hF, 1'b0);
    send(32'h00000066, 4'hF, 1'b0);
    send(32'h00000077, 4'hF, 1'b1);
    push(2'b11, 32'h52524343, 4'hF, 1'b0, 4'd2, 32'h0A);
    push(2'b11, 32'hC0C00003, 4'hF, 1'b1, 4'd2, 32'h0A);
    send(32'h52524343, 4'hF, 1'b0);
    send(32'h0000000A, 4'hF, 1'b0);
    send(32'hC0C00003, 4'hF, 1'b1);
    drain();

    // ID 7 twice: second copy only survives without de-duplication.
    for (int r = 0; r < 2; r++) begin
      push(r == 0 ? 2'b11 : 2'b10, 32'h57574343, 4'hF, 1'b0, 4'd0, 32'd7);
      push(r == 0 ? 2'b11 : 2'b10, 32'hA0A00001, 4'hF, 1'b0, 4'd0, 32'd7);
      push(r == 0 ? 2'b11 : 2'b10, 32'hB0B00002, 4'h3, 1'b1, 4'd0, 32'd7);
      send(32'h57574343, 4'hF, 1'b0);
      send(32'h00000007, 4'hF, 1'b0);
      chk($sformatf("dup_pulse_%0d", r), 64'(p_dup[0]), r == 0 ? 64'd0 : 64'd1);
      send(32'hA0A00001, 4'hF, 1'b0);
      send(32'hB0B00002, 4'h3, 1'b1);
    end
    drain();

    // Truncated frame, then decode disable in IDLE.
    send(32'h57574646, 4'hF, 1'b1);
    chk("err_short_pulse", 64'(p_short[0]), 64'd1);
    @(posedge clk);
    #1;
    chk("err_short_one_cycle", 64'(p_short[0]), 64'd0);
    en = 1'b0;
    @(negedge clk);
    chk("disabled_ready", 64'({in_ready[1], in_ready[0]}), 64'd0);
    en = 1'b1;
    @(posedge clk);
    #1;
    push(2'b11, 32'h57574646, 4'hF, 1'b0, 4'd1, 32'h33);
    push(2'b11, 32'hD0D00004, 4'hF, 1'b1, 4'd1, 32'h33);
    send(32'h57574646, 4'hF, 1'b0);
    send(32'h00000033, 4'hF, 1'b0);
    send(32'hD0D00004, 4'hF, 1'b1);
    drain();

    // Reset while a payload beat is stalled in the output register.
    push(2'b11, 32'h57574343, 4'hF, 1'b0, 4'd0, 32'd7);
    push(2'b11, 32'hE0E00001, 4'hF, 1'b0, 4'd0, 32'd7);
    push(2'b11, 32'hE0E00002, 4'hF, 1'b0, 4'd0, 32'd7);
    send(32'h57574343, 4'hF, 1'b0);
    send(32'h00000007, 4'hF, 1'b0);
    send(32'hE0E00001, 4'hF, 1'b0);
    send(32'hE0E00002, 4'hF, 1'b0);
    tready_mode = 0;
    in_data = 32'hE0E00003; in_keep = 4'hF; in_last = 1'b0; in_valid = 2'b11;
    repeat (2) @(posedge clk);
    #3;
    chk("stalled_tvalid", 64'(o_valid[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("reset_drops_tvalid", 64'({o_valid[1], o_valid[0]}), 64'd0);
    exp_q[0].delete();
    exp_q[1].delete();
    in_valid = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tready_mode = 1;
    push(2'b11, 32'h57574343, 4'hF, 1'b0, 4'd0, 32'd7);
    push(2'b11, 32'hF0F00001, 4'hF, 1'b1, 4'd0, 32'd7);
    send(32'h57574343, 4'hF, 1'b0);
    send(32'h00000007, 4'hF, 1'b0);
    send(32'hF0F00001, 4'hF, 1'b1);
    drain();

    chk("cnt_err_unknown", 64'(cnt_unk[0]), 64'd1);
    chk("cnt_err_short", 64'(cnt_short[0]), 64'd1);
    chk("cnt_dup_drop", 64'(cnt_dup[0]), 64'd1);
    chk("cnt_dup_drop_nodedup", 64'(cnt_dup[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
